calculo_preco: RTL and testbench
================================

CALCULO_PRECO -- requirements
Module: calculo_preco

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Port: clk  input  1  system clock.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: peso  input  10  weight in grams, valid range 0..999.
REQ-006 Port: precokg  input  10  unit price in cents per kg, valid range 0..999.
REQ-007 Port: centimos  output  10  total price in cents; feeds the cents-to-euros converter directly.
REQ-008 Port: ocupado  output  1  high while a computation is in progress.
REQ-009 Port: pronto  output  1  one-cycle pulse when centimos and erro are updated.
REQ-010 Port: erro  output  1  high when the last request had an out-of-range operand.

Function
REQ-011 States SHALL be IDLE, MULT, DIV and FIM.
REQ-012 IDLE with start=1 SHALL latch peso and precokg on that edge, set ocupado=1 and enter MULT.
REQ-013 If the latched peso>999 or precokg>999, the module SHALL go directly to FIM, set erro=1 and set centimos=0.
REQ-014 MULT SHALL form the 20-bit product peso*precokg by shift-add, one bit per cycle, over exactly 10 cycles.
REQ-015 DIV SHALL compute floor(product/1000) by restoring division, one quotient bit per cycle, over exactly 10 cycles.
- Divisor starts as 1000<<9.
- Quotient bits are produced 9 down to 0.
REQ-016 FIM SHALL last one cycle.
- Load centimos with the quotient and erro with 0, or apply the values from REQ-013.
- Pulse pronto=1 and drop ocupado.
- Return to IDLE.
REQ-017 Latency for a valid request SHALL be exactly 21 cycles: pronto is high in the 21st cycle after the edge that accepted start.
REQ-018 Latency for an invalid request SHALL be 1 cycle: pronto is high in the cycle after acceptance.
REQ-019 Start asserted while ocupado=1 SHALL be ignored, with no queuing.
REQ-020 Start held high SHALL begin a new request in the cycle after FIM, since IDLE samples it again.
REQ-021 centimos and erro SHALL hold their values between pronto pulses and SHALL NOT show intermediate results.
REQ-022 The maximum result, 999*999/1000, is 998 and SHALL fit in 10 bits with no saturation logic.
REQ-023 Operands SHALL NOT be re-sampled during a computation; input changes while ocupado=1 SHALL have no effect.

Reset
REQ-024 rst=1 SHALL force IDLE with centimos=0, ocupado=0, pronto=0 and erro=0, and clear all internal registers.
REQ-025 rst asserted mid-computation SHALL abort it with no pronto pulse; the next start after rst deasserts SHALL run normally.
REQ-026 rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 Macro ARREDONDAR_EN SHALL control rounding of the result.
- Defined: 500 is added to the product before DIV, rounding to the nearest cent with halves rounded up; latency is unchanged.
- Undefined: the result is truncated to floor(product/1000).

Verification
REQ-028 peso=500, precokg=940, one start pulse -> pronto in cycle 21, centimos=470, erro=0, ocupado high for cycles 1..20.
REQ-029 peso=335, precokg=100 -> centimos=33 without ARREDONDAR_EN, 34 with it; peso=999, precokg=999 -> 998 in both builds.
REQ-030 peso=1000, precokg=5 -> pronto in cycle 1 after acceptance, erro=1, centimos=0; a following valid request clears erro.
REQ-031 start re-pulsed at cycle 7 of a computation with different operands -> ignored; result matches the first operands; exactly one pronto.
REQ-032 rst pulsed at cycle 12 of a computation -> no pronto, all outputs 0; peso=0, precokg=999 started after reset -> centimos=0, erro=0 at cycle 21.

Source files
------------

// File: rtl/calculo_preco.sv
// calculo_preco: price = peso[g] * precokg[cents/kg] / 1000, in cents.
// Sequential shift-add multiply (10 cycles) followed by restoring division
// by 1000 (10 cycles), then a one-cycle FIM state that publishes the result.
// Operands above 999 are rejected immediately with erro=1 and centimos=0.
// Build option: define ARREDONDAR_EN to round to the nearest cent (halves up)
// instead of truncating; latency is the same in both builds.
module calculo_preco (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] peso,
    input  logic [9:0] precokg,
    output logic [9:0] centimos,
    output logic       ocupado,
    output logic       pronto,
    output logic       erro
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIM} state_t;

`ifdef ARREDONDAR_EN
    localparam logic [19:0] BIAS = 20'd500;
`else
    localparam logic [19:0] BIAS = 20'd0;
`endif
    // Divisor aligned so the first compare produces quotient bit 9.
    localparam logic [19:0] DIVISOR_INIT = 20'd1000 << 9;

    state_t      state, state_next;
    logic [19:0] multiplicando;   // peso, shifted left once per MULT cycle
    logic [9:0]  multiplicador;   // precokg, shifted right once per MULT cycle
    logic [19:0] acc;             // running product
    logic [19:0] resto;           // partial remainder during DIV
    logic [19:0] divisor;         // 1000 << (9 - bit index)
    logic [9:0]  quoc;            // quotient, filled MSB first
    logic [3:0]  count;           // step counter shared by MULT and DIV

    logic        invalid;
    logic        last_step;
    logic [19:0] acc_next;
    logic        q_bit;
    logic [19:0] resto_next;
    logic [9:0]  quoc_next;

    assign invalid    = (peso > 10'd999) || (precokg > 10'd999);
    assign last_step  = (count == 4'd9);
    assign acc_next   = acc + (multiplicador[0] ? multiplicando : 20'd0);
    assign q_bit      = (resto >= divisor);
    assign resto_next = q_bit ? (resto - divisor) : resto;
    assign quoc_next  = {quoc[8:0], q_bit};

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: all clocked state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and the status outputs decoded from the state.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned
        // (which would infer a latch).
        state_next = state;
        ocupado    = 1'b0;
        pronto     = 1'b0;
        case (state)
            IDLE: if (start) state_next = invalid ? FIM : MULT;
            MULT: begin
                ocupado = 1'b1;
                if (last_step) state_next = DIV;
            end
            DIV: begin
                ocupado = 1'b1;
                if (last_step) state_next = FIM;
            end
            FIM: begin
                pronto     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add multiply, restoring divide and
    // result registers (updated only on the edge that enters FIM).
    always_ff @(posedge clk) begin
        // NOTE: every register is cleared by rst, so an aborted computation
        // leaves no residue and the outputs read 0 immediately.
        if (rst) begin
            multiplicando <= '0;
            multiplicador <= '0;
            acc           <= '0;
            resto         <= '0;
            divisor       <= '0;
            quoc          <= '0;
            count         <= '0;
            centimos      <= '0;
            erro          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    multiplicando <= {10'd0, peso};
                    multiplicador <= precokg;
                    acc           <= '0;
                    count         <= '0;
                    if (invalid) begin
                        centimos <= '0;
                        erro     <= 1'b1;
                    end
                end
                MULT: begin
                    acc           <= acc_next;
                    multiplicando <= multiplicando << 1;
                    multiplicador <= multiplicador >> 1;
                    if (last_step) begin
                        count   <= '0;
                        resto   <= acc_next + BIAS;
                        divisor <= DIVISOR_INIT;
                        quoc    <= '0;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                DIV: begin
                    resto   <= resto_next;
                    divisor <= divisor >> 1;
                    quoc    <= quoc_next;
                    count   <= count + 4'd1;
                    if (last_step) begin
                        centimos <= quoc_next;
                        erro     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calculo_preco.sv
// Self-checking bench for calculo_preco: directed cases plus random operands,
// compared against an arithmetic price model.
module tb_calculo_preco;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] peso;
    logic [9:0] precokg;
    logic [9:0] centimos;
    logic       ocupado;
    logic       pronto;
    logic       erro;

    int passed = 0;
    int total  = 0;

    calculo_preco dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .peso     (peso),
        .precokg  (precokg),
        .centimos (centimos),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .erro     (erro)
    );

    always #5 clk = ~clk;

    // Reference price in cents.
    function automatic int model_price(input int p, input int q);
`ifdef ARREDONDAR_EN
        return (p * q + 500) / 1000;
`else
        return (p * q) / 1000;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Issue one request and watch 30 cycles after acceptance.
    // repulse_at: cycle at which start is re-pulsed with other operands (0 = never).
    // rst_at: cycle at which rst is pulsed (0 = never); expects abort.
    task automatic run_req(input string tag, input int p, input int q,
                           input int repulse_at, input int rst_at);
        int         seen;
        int         pulses;
        int         lat;
        int         exp_c;
        int         exp_e;
        logic       ocup_bad;
        logic [9:0] c_at;
        logic       e_at;
        logic       bad_op;
        seen     = 0;
        pulses   = 0;
        ocup_bad = 1'b0;
        c_at     = '0;
        e_at     = 1'b0;
        bad_op   = (p > 999) || (q > 999);
        exp_c    = bad_op ? 0 : model_price(p, q);
        exp_e    = bad_op ? 1 : 0;
        lat      = bad_op ? 1 : 21;

        @(negedge clk);
        peso    = p[9:0];
        precokg = q[9:0];
        start   = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (pronto === 1'b1) begin
                pulses++;
                if (seen == 0) begin
                    seen = k;
                    c_at = centimos;
                    e_at = erro;
                end
            end
            if (rst_at == 0 && k <= lat && ocupado !== (k < lat)) ocup_bad = 1'b1;
            if (seen != 0 && k == seen + 1)
                check({tag, " hold"}, {22'd0, centimos}, {22'd0, c_at});
            if (rst_at > 0 && k == rst_at + 1) begin
                check({tag, " after rst"}, {19'd0, centimos, ocupado, pronto, erro}, 32'd0);
                rst = 1'b0;
            end
            if (rst_at > 0 && k == rst_at) rst = 1'b1;
            if (repulse_at > 0 && k == repulse_at) begin
                start   = 1'b1;
                peso    = 10'd123;
                precokg = 10'd456;
            end
            if (repulse_at > 0 && k == repulse_at + 1) start = 1'b0;
        end

        if (rst_at > 0) begin
            check({tag, " pronto count"}, pulses, 0);
        end else begin
            check({tag, " latency"},     seen, lat);
            check({tag, " pronto count"}, pulses, 1);
            check({tag, " centimos"},    {22'd0, c_at}, exp_c);
            check({tag, " erro"},        {31'd0, e_at}, exp_e);
            check({tag, " ocupado"},     {31'd0, ocup_bad}, 0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        peso    = '0;
        precokg = '0;
        repeat (2) @(negedge clk);
        check("reset centimos", {22'd0, centimos}, 0);
        check("reset ocupado",  {31'd0, ocupado},  0);
        check("reset pronto",   {31'd0, pronto},   0);
        check("reset erro",     {31'd0, erro},     0);
        rst = 1'b0;

        run_req("500x940", 500, 940, 0, 0);
        run_req("335x100", 335, 100, 0, 0);
        run_req("999x999", 999, 999, 0, 0);
        run_req("1000x5",  1000, 5, 0, 0);
        run_req("after err", 200, 300, 0, 0);
        run_req("5x1023",  5, 1023, 0, 0);
        run_req("repulse", 640, 777, 7, 0);
        run_req("rst abort", 999, 999, 0, 12);
        run_req("0x999",   0, 999, 0, 0);

        // rst wins over start in the same cycle.
        @(negedge clk);
        rst     = 1'b1;
        start   = 1'b1;
        peso    = 10'd5;
        precokg = 10'd5;
        @(negedge clk);
        check("rst priority ocupado", {31'd0, ocupado}, 0);
        check("rst priority pronto",  {31'd0, pronto},  0);
        rst   = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 8; i++)
            run_req("random", int'($urandom_range(0, 999)), int'($urandom_range(0, 999)), 0, 0);
        run_req("random bad", int'($urandom_range(1000, 1023)), int'($urandom_range(0, 1023)), 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
